hazard_stall_controller: RTL
============================

Name: hazard_stall_controller

Overview:
- Pipeline hazard sequencer for the RV32IM core; sits beside the forwarding unit in the ID stage.
- Tracks destination registers of in-flight instructions in EX and MEM and supplies them as RD_IMM_OLD and RD_OLD_OLD to the forwarding unit.
- Detects load-use hazards and inserts one bubble.
- Sequences the multi-cycle divider (start pulse, busy stall) and applies branch-taken flushes.

Parameters:
DIV_CYCLES, 32, cycles the divider needs from DIV_START to result valid (>=1)
DIV_CNT_W, 6, counter width; must hold DIV_CYCLES

Ports:
CLK  input  1  core clock, rising edge
RESET  input  1  synchronous, active-low reset
INSTRUCTION  input  32  instruction currently in ID
ID_VALID  input  1  ID holds a real instruction
BRANCH_TAKEN  input  1  EX resolved a taken branch/jump this cycle
STALL  output  1  hold PC and IF/ID; inject bubble into ID/EX
FLUSH  output  1  squash IF/ID and ID/EX contents
DIV_START  output  1  one-cycle start pulse to divider
DIV_BUSY  output  1  divider sequence in progress
RD_IMM_OLD  output  5  rd of instruction in EX (0 = no producer)
RD_OLD_OLD  output  5  rd of instruction in MEM (0 = no producer)

Behaviour:
- Reset (RESET=0 at a rising edge): EX_RD, EX_LOAD, MEM_RD and div counter cleared. All outputs 0 from the next cycle on. A reset mid-divide abandons the sequence and produces no DIV_START.
- Decode of INSTRUCTION, opcode [6:0]:
  - writes_rd: R 0110011, I-ALU 0010011, LOAD 0000011, LUI 0110111, AUIPC 0010111, JAL 1101111, JALR 1100111; only when rd!=0.
  - uses_rs1: all except LUI, AUIPC, JAL.
  - uses_rs2: R, STORE 0100011, BRANCH 1100011.
  - is_div: opcode 0110011, funct7 0000001, funct3[2]=1.
- load_use = ID_VALID & EX_LOAD & EX_RD!=0 & ((uses_rs1 & rs1==EX_RD) | (uses_rs2 & rs2==EX_RD)).
- FLUSH = BRANCH_TAKEN, combinational.
- STALL = !FLUSH & (DIV_BUSY | load_use), combinational.
- Next-state priority per cycle: reset > flush > div busy > load-use > normal.
  - Flush: EX_RD<=0, EX_LOAD<=0, MEM_RD<=EX_RD. A pending div issue in ID is dropped. An in-progress div continues.
  - Div busy (counter!=0): counter decrements. EX_RD/EX_LOAD frozen (div owns EX). MEM_RD<=0.
  - Load-use: bubble. EX_RD<=0, EX_LOAD<=0, MEM_RD<=EX_RD.
  - Normal: MEM_RD<=EX_RD. EX_RD<=(ID_VALID & writes_rd) ? rd : 0. EX_LOAD<=ID_VALID & opcode==LOAD.
- Divider sequencing:
  - On a normal-path issue with is_div, DIV_START=1 for exactly that cycle and counter<=DIV_CYCLES.
  - DIV_BUSY = counter!=0 (registered, visible the cycle after DIV_START).
  - When the counter reaches 0, the next cycle resumes the normal path and the div rd advances to MEM.
  - No DIV_START while DIV_BUSY=1.
- RD_IMM_OLD=EX_RD and RD_OLD_OLD=MEM_RD, registered, zero-latency read.
- No state change when ID_VALID=0 except the bubble shift (EX_RD<=0).

Optional Feature:
- Macro HAZARD_PERF_COUNT_EN.
- Defined: adds outputs STALL_COUNT[31:0] and FLUSH_COUNT[31:0].
  - Each increments by 1 on every clock with STALL=1 / FLUSH=1, wraps 0xFFFFFFFF->0, and clears on reset.
- Undefined: ports and counters are absent, with identical remaining behaviour.

Test Plan:
- Reset: hold RESET=0 two cycles with random INSTRUCTION -> STALL=FLUSH=DIV_START=DIV_BUSY=0, RD_IMM_OLD=RD_OLD_OLD=0.
- Load-use: issue lw x5,0(x1) (0x0000A283), then add x6,x5,x7 (0x00728333) -> STALL=1 exactly one cycle, RD_IMM_OLD 5 then 0 (bubble), RD_OLD_OLD=5. The add issues the next cycle, then RD_IMM_OLD=6.
- Non-hazard: lw x5 followed by add x6,x1,x7 -> STALL stays 0, RD_IMM_OLD=6 and RD_OLD_OLD=5 one cycle later.
- Divide, DIV_CYCLES=4: issue div x8,x6,x7 (0x02734433) -> DIV_START pulses once, DIV_BUSY=1 and STALL=1 for 4 cycles, RD_IMM_OLD=8 held, RD_OLD_OLD=0 during busy, 8 after release.
- Flush precedence: BRANCH_TAKEN=1 in the same cycle as a load-use condition -> FLUSH=1, STALL=0, EX_RD cleared. BRANCH_TAKEN during DIV_BUSY -> FLUSH=1, divide completes on schedule.
- Reset mid-divide: RESET=0 at busy cycle 2 -> DIV_BUSY=0 the next cycle, no further STALL. With HAZARD_PERF_COUNT_EN, counters read 0 after reset and count 1 per stalled cycle afterwards.

Source files
------------

// File: rtl/hazard_stall_controller.sv
// -----------------------------------------------------------------------------
// hazard_stall_controller
//
// Hazard sequencer for the RV32IM core. It sits beside the forwarding unit in
// the ID stage and does four things:
//   - tracks the destination register of the instructions in EX and MEM and
//     presents them to the forwarding unit (RD_IMM_OLD / RD_OLD_OLD),
//   - detects load-use hazards and inserts a single bubble,
//   - sequences the multi-cycle divider (start pulse, then busy stall),
//   - applies branch-taken flushes.
//
// Parameters:
//   DIV_CYCLES   cycles the divider needs from DIV_START to result (>= 1)
//   DIV_CNT_W    width of the divide counter; must be able to hold DIV_CYCLES
//
// Ports:
//   CLK           core clock, rising edge
//   RESET         synchronous, active-low reset
//   INSTRUCTION   instruction currently in ID
//   ID_VALID      ID holds a real instruction
//   BRANCH_TAKEN  EX resolved a taken branch/jump this cycle
//   STALL         hold PC and IF/ID, inject a bubble into ID/EX
//   FLUSH         squash IF/ID and ID/EX contents
//   DIV_START     one-cycle start pulse to the divider
//   DIV_BUSY      divide sequence in progress
//   RD_IMM_OLD    rd of the instruction in EX  (0 = no producer)
//   RD_OLD_OLD    rd of the instruction in MEM (0 = no producer)
//   STALL_COUNT   (HAZARD_PERF_COUNT_EN only) clocks spent with STALL=1
//   FLUSH_COUNT   (HAZARD_PERF_COUNT_EN only) clocks spent with FLUSH=1
//
// Build option:
//   HAZARD_PERF_COUNT_EN  when defined, adds the two wrapping 32-bit
//                         performance counters above. When undefined the
//                         ports and counters are absent.
//
// Handshake: there is no valid/ready pair here. ID_VALID qualifies
// INSTRUCTION in the same cycle; STALL tells the pipeline to hold the
// instruction in ID, which is then presented again on the next cycle.
// -----------------------------------------------------------------------------
module hazard_stall_controller #(
    parameter int DIV_CYCLES = 32,
    parameter int DIV_CNT_W  = 6
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic [31:0] INSTRUCTION,
    input  logic        ID_VALID,
    input  logic        BRANCH_TAKEN,
    output logic        STALL,
    output logic        FLUSH,
    output logic        DIV_START,
    output logic        DIV_BUSY,
    output logic [4:0]  RD_IMM_OLD,
    output logic [4:0]  RD_OLD_OLD
`ifdef HAZARD_PERF_COUNT_EN
    ,
    output logic [31:0] STALL_COUNT,
    output logic [31:0] FLUSH_COUNT
`endif
);

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I_ALU  = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    localparam logic [DIV_CNT_W-1:0] DIV_CNT_INIT = DIV_CNT_W'(DIV_CYCLES);
    localparam logic [DIV_CNT_W-1:0] DIV_CNT_ONE  = DIV_CNT_W'(1);

    // Which update rule the pipeline tracking registers follow this cycle,
    // in priority order flush > div busy > load-use > normal.
    typedef enum logic [1:0] {
        PATH_NORMAL   = 2'd0,
        PATH_FLUSH    = 2'd1,
        PATH_DIV_BUSY = 2'd2,
        PATH_LOAD_USE = 2'd3
    } path_e;

    // Tracking state
    logic [4:0]           ex_rd;
    logic                 ex_load;
    logic [4:0]           mem_rd;
    logic [DIV_CNT_W-1:0] div_cnt;

    // Instruction fields
    logic [6:0] opcode;
    logic [4:0] rd;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [6:0] funct7;
    logic       funct3_msb;
    logic       unused_funct3_low;

    assign opcode            = INSTRUCTION[6:0];
    assign rd                = INSTRUCTION[11:7];
    assign rs1               = INSTRUCTION[19:15];
    assign rs2               = INSTRUCTION[24:20];
    assign funct7            = INSTRUCTION[31:25];
    assign funct3_msb        = INSTRUCTION[14];
    // Only funct3[2] separates DIV/DIVU/REM/REMU from the MUL group.
    assign unused_funct3_low = ^INSTRUCTION[13:12];

    // Decode
    logic writes_rd;
    logic uses_rs1;
    logic uses_rs2;
    logic is_div;
    logic is_load;

    always_comb begin
        writes_rd = 1'b0;
        case (opcode)
            OP_R, OP_I_ALU, OP_LOAD, OP_LUI, OP_AUIPC, OP_JAL, OP_JALR:
                writes_rd = (rd != 5'd0);
            default:
                writes_rd = 1'b0;
        endcase
    end

    // Every opcode reads rs1 except the three that form their result from
    // the immediate and/or PC only.
    assign uses_rs1 = (opcode != OP_LUI) && (opcode != OP_AUIPC) && (opcode != OP_JAL);
    assign uses_rs2 = (opcode == OP_R) || (opcode == OP_STORE) || (opcode == OP_BRANCH);
    assign is_div   = (opcode == OP_R) && (funct7 == 7'b0000001) && funct3_msb;
    assign is_load  = (opcode == OP_LOAD);

    // Hazard detection
    logic div_busy;
    logic load_use;
    path_e path;

    assign div_busy = (div_cnt != '0);

    assign load_use = ID_VALID && ex_load && (ex_rd != 5'd0) &&
                      ((uses_rs1 && (rs1 == ex_rd)) || (uses_rs2 && (rs2 == ex_rd)));

    always_comb begin
        path = PATH_NORMAL;
        if (BRANCH_TAKEN) begin
            path = PATH_FLUSH;
        end else if (div_busy) begin
            path = PATH_DIV_BUSY;
        end else if (load_use) begin
            path = PATH_LOAD_USE;
        end
    end

    // A divide only launches when it actually leaves ID on the normal path;
    // a divide held by a flush, stall or reset never pulses the divider.
    logic div_issue;
    assign div_issue = RESET && (path == PATH_NORMAL) && ID_VALID && is_div;

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            ex_rd   <= 5'd0;
            ex_load <= 1'b0;
            mem_rd  <= 5'd0;
            div_cnt <= '0;
        end else begin
            case (path)
                PATH_FLUSH: begin
                    ex_rd   <= 5'd0;
                    ex_load <= 1'b0;
                    mem_rd  <= ex_rd;
                    // The divider itself is not squashed; keep its schedule.
                    if (div_busy) begin
                        div_cnt <= div_cnt - DIV_CNT_ONE;
                    end
                end
                PATH_DIV_BUSY: begin
                    // The divide owns EX, so EX tracking is frozen and MEM
                    // sees nothing new.
                    div_cnt <= div_cnt - DIV_CNT_ONE;
                    mem_rd  <= 5'd0;
                end
                PATH_LOAD_USE: begin
                    ex_rd   <= 5'd0;
                    ex_load <= 1'b0;
                    mem_rd  <= ex_rd;
                end
                default: begin
                    mem_rd  <= ex_rd;
                    ex_rd   <= (ID_VALID && writes_rd) ? rd : 5'd0;
                    ex_load <= ID_VALID && is_load;
                    if (div_issue) begin
                        div_cnt <= DIV_CNT_INIT;
                    end
                end
            endcase
        end
    end

    assign FLUSH      = BRANCH_TAKEN;
    assign STALL      = !BRANCH_TAKEN && (div_busy || load_use);
    assign DIV_START  = div_issue;
    assign DIV_BUSY   = div_busy;
    assign RD_IMM_OLD = ex_rd;
    assign RD_OLD_OLD = mem_rd;

`ifdef HAZARD_PERF_COUNT_EN
    logic [31:0] stall_count;
    logic [31:0] flush_count;

    // Both counters wrap naturally at 32 bits.
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            stall_count <= 32'd0;
            flush_count <= 32'd0;
        end else begin
            if (STALL) begin
                stall_count <= stall_count + 32'd1;
            end
            if (FLUSH) begin
                flush_count <= flush_count + 32'd1;
            end
        end
    end

    assign STALL_COUNT = stall_count;
    assign FLUSH_COUNT = flush_count;
`endif

endmodule
